// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - shared types and constants for the NES pad poller
// Holds the poller state enum, the button bit masks and the number of serial
// bits read per poll. Defining PAD_POLLER_DETECT_EN widens the read to 16 bits
// so the pad-presence signature in bits 8..15 can be checked.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_t;

  localparam logic [7:0] BTN_A      = 8'h01;
  localparam logic [7:0] BTN_B      = 8'h02;
  localparam logic [7:0] BTN_SELECT = 8'h04;
  localparam logic [7:0] BTN_START  = 8'h08;
  localparam logic [7:0] BTN_UP     = 8'h10;
  localparam logic [7:0] BTN_DOWN   = 8'h20;
  localparam logic [7:0] BTN_LEFT   = 8'h40;
  localparam logic [7:0] BTN_RIGHT  = 8'h80;

`ifdef PAD_POLLER_DETECT_EN
  localparam int NBITS = 16;
`else
  localparam int NBITS = 8;
`endif

  localparam int BIT_W = $clog2(NBITS);

endpackage

// File: rtl/pad_sync2.sv
// rtl/pad_sync2.sv - two-flop synchronizer for the pad serial data line
// Ports: clk, rst (sync, active-high), d (asynchronous input), q (synchronized).
// Resets to 1 because the data line idles high (released / pulled up).
module pad_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_poller.sv
// rtl/nes_pad_poller.sv - host-side NES controller poller
// Drives latch/shift-clock to a physical NES pad, shifts in the active-low
// serial data LSB-first and publishes an active-high button byte per poll.
// Ports:
//   clk, rst        master clock, synchronous active-high reset
//   poll_req        one-cycle request to poll now (ignored outside IDLE)
//   pad_data        asynchronous serial data from the pad, 0 = pressed
//   pad_latch       latch strobe to the pad, active-high
//   pad_clk         shift clock to the pad, idles high
//   btns            button state, 1 = pressed (A,B,Select,Start,Up,Down,Left,Right)
//   btns_valid      one-cycle pulse when btns is updated
//   pad_present     pad detected
// Build option PAD_POLLER_DETECT_EN: read 16 bits and derive pad_present from
// bits 8..15; otherwise pad_present latches high on the first completed poll.
module nes_pad_poller #(
  parameter int HALF_CYCLES = 128,
  parameter int POLL_CYCLES = 357954
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] btns,
  output logic       btns_valid,
  output logic       pad_present
);

  import nes_pad_pkg::*;

  localparam int HC_W  = $clog2(2 * HALF_CYCLES);
  localparam int CNT_W = $clog2(POLL_CYCLES);

  pad_state_t         state;
  pad_state_t         state_next;
  logic [HC_W-1:0]    hc;
  logic [BIT_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   poll_cnt;
  logic [NBITS-1:0]   shift;
  logic [NBITS-1:0]   shift_next;
  logic               sync_q;
  logic               half_end;
  logic               latch_end;
  logic               last_bit;
  logic               poll_due;
  logic               sample_en;

  logic               latch_d;
  logic               clk_d;
  logic               valid_d;
  logic [7:0]         btns_d;
  logic               present_d;

  pad_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_data),
    .q   (sync_q)
  );

  assign half_end  = (hc == HC_W'(HALF_CYCLES - 1));
  assign latch_end = (hc == HC_W'(2 * HALF_CYCLES - 1));
  assign last_bit  = (bit_idx == BIT_W'(NBITS - 1));
  assign poll_due  = (poll_cnt == CNT_W'(POLL_CYCLES - 1));

  // Bits are sampled on the last cycle of SETTLE (bit 0) and of each CLK_HI.
  assign sample_en  = half_end && ((state == SETTLE) || (state == CLK_HI));
  assign shift_next = sample_en ? {~sync_q, shift[NBITS-1:1]} : shift;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (poll_due || poll_req) state_next = LATCH;
      LATCH:   if (latch_end) state_next = SETTLE;
      SETTLE:  if (half_end) state_next = CLK_LO;
      CLK_LO:  if (half_end) state_next = CLK_HI;
      CLK_HI:  if (half_end) state_next = last_bit ? DONE : CLK_LO;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic, evaluated on the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    latch_d = (state_next == LATCH);
    clk_d   = (state_next != CLK_LO);
    valid_d = (state_next == DONE);
`ifdef PAD_POLLER_DETECT_EN
    // An official pad shifts out its grounded serial input after 8 bits,
    // which reads as 1s; an open line reads all zeros.
    present_d = &shift_next[15:8];
    btns_d    = present_d ? shift_next[7:0] : 8'h00;
`else
    present_d = 1'b1;
    btns_d    = shift_next[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_latch   <= 1'b0;
      pad_clk     <= 1'b1;
      btns        <= 8'h00;
      btns_valid  <= 1'b0;
      pad_present <= 1'b0;
    end else begin
      pad_latch  <= latch_d;
      pad_clk    <= clk_d;
      btns_valid <= valid_d;
      if (valid_d) begin
        btns        <= btns_d;
        pad_present <= present_d;
      end
    end
  end

  // Datapath: half-period counter, bit index, poll counter, shift register.
  // The poll counter runs through transactions so polls stay periodic.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc       <= '0;
      bit_idx  <= '0;
      poll_cnt <= '0;
      shift    <= '0;
    end else begin
      hc       <= (state_next != state) ? '0 : hc + HC_W'(1);
      poll_cnt <= ((state == IDLE) && (state_next == LATCH)) ? '0 : poll_cnt + CNT_W'(1);
      if (state == LATCH) begin
        bit_idx <= '0;
      end else if (sample_en) begin
        bit_idx <= bit_idx + BIT_W'(1);
      end
      shift <= shift_next;
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// tb/tb_nes_pad_poller.sv - testbench for nes_pad_poller
module tb_nes_pad_poller;
  import nes_pad_pkg::*;

  localparam int H = 4;
  localparam int P = 1000;
`ifdef PAD_POLLER_DETECT_EN
  localparam bit DET = 1'b1;
  localparam int NB  = 16;
`else
  localparam bit DET = 1'b0;
  localparam int NB  = 8;
`endif
  localparam int VALID_OFF = 3 * H + (NB - 1) * 2 * H;
  localparam int WIN       = VALID_OFF + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_req = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] btns;
  logic       btns_valid;
  logic       pad_present;

  nes_pad_poller #(.HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .poll_req    (poll_req),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .btns        (btns),
    .btns_valid  (btns_valid),
    .pad_present (pad_present)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Pad model: word bit k = 1 means the pad drives serial position k low.
  // Position resets when the latch drops and advances on each pad_clk rise.
  logic [15:0] pad_word = 16'h0;
  bit          pad_disc = 1'b0;
  int          rise_cnt = 0;
  int          snap = 0;
  int          pad_idx;

  always @(posedge pad_clk) rise_cnt <= rise_cnt + 1;
  always @(negedge pad_latch) snap <= rise_cnt;
  assign pad_idx = rise_cnt - snap;

  always_comb begin
    pad_data = 1'b0;
    if (pad_disc) pad_data = 1'b1;
    else if (pad_idx >= 0 && pad_idx < 16) pad_data = ~pad_word[pad_idx];
  end

  // Expected {pad_present, btns} after a poll of the given pad.
  function automatic logic [8:0] model(input logic [15:0] w, input bit disc);
    logic [15:0] r;
    logic p;
    r = disc ? 16'h0 : w;
    if (DET) begin
      p = (r[15:8] == 8'hFF);
      return {p, p ? r[7:0] : 8'h00};
    end
    return {1'b1, r[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         ob_found, ob_start, ob_lat, ob_pulses, ob_first_low;
  int         ob_low_min, ob_low_max, ob_vcnt, ob_voff;
  logic [7:0] ob_btns;
  logic       ob_pres;

  // Waits (from a negedge) for pad_latch, then records one transaction window.
  // req_off >= 0 pulses poll_req at that offset into the transaction.
  task automatic observe(input int max_wait, input int req_off);
    int   run;
    logic prev_clk;
    ob_found = 0; ob_start = -1; ob_lat = 0; ob_pulses = 0; ob_first_low = -1;
    ob_low_min = 9999; ob_low_max = 0; ob_vcnt = 0; ob_voff = -1;
    ob_btns = 8'h00; ob_pres = 1'b0;
    for (int i = 0; i < max_wait && !pad_latch; i++) @(negedge clk);
    if (!pad_latch) return;
    ob_found = 1;
    ob_start = cyc;
    run = 0;
    prev_clk = 1'b1;
    for (int o = 0; o < WIN; o++) begin
      if (pad_latch) ob_lat++;
      if (!pad_clk) begin
        run++;
        if (prev_clk) begin
          ob_pulses++;
          if (ob_first_low < 0) ob_first_low = o;
        end
      end else if (run > 0) begin
        if (run < ob_low_min) ob_low_min = run;
        if (run > ob_low_max) ob_low_max = run;
        run = 0;
      end
      if (btns_valid) begin
        ob_vcnt++;
        if (ob_voff < 0) begin
          ob_voff = o;
          ob_btns = btns;
          ob_pres = pad_present;
        end
      end
      prev_clk = pad_clk;
      poll_req = (o == req_off);
      @(negedge clk);
    end
    poll_req = 1'b0;
  endtask

  task automatic check_txn(input string tag);
    logic [8:0] e;
    e = model(pad_word, pad_disc);
    check({tag, "_found"}, ob_found, 1);
    check({tag, "_latch_len"}, ob_lat, 2 * H);
    check({tag, "_pulses"}, ob_pulses, NB - 1);
    check({tag, "_first_low"}, ob_first_low, 3 * H);
    check({tag, "_low_min"}, ob_low_min, H);
    check({tag, "_low_max"}, ob_low_max, H);
    check({tag, "_valid_cnt"}, ob_vcnt, 1);
    check({tag, "_valid_off"}, ob_voff, VALID_OFF);
    check({tag, "_btns"}, ob_btns, e[7:0]);
    check({tag, "_present"}, ob_pres, e[8]);
  endtask

  task automatic run_poll(input string tag);
    int cr;
    poll_req = 1'b1;
    cr = cyc;
    @(negedge clk);
    poll_req = 1'b0;
    observe(2, -1);
    check({tag, "_start"}, ob_start, cr + 1);
    check_txn(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s1, s2, vcnt, n;
    repeat (3) @(negedge clk);
    check("rst_latch", pad_latch, 0);
    check("rst_clk", pad_clk, 1);
    check("rst_btns", btns, 0);
    check("rst_valid", btns_valid, 0);
    check("rst_present", pad_present, 0);
    rst = 1'b0;

    // Start + Right via poll_req at cycle 10
    pad_word = {8'hFF, BTN_START | BTN_RIGHT};
    repeat (10) @(negedge clk);
    run_poll("start_right");
    check("start_right_const", ob_btns, 8'h88);

    // Random button patterns and random presence signatures
    for (int i = 0; i < 4; i++) begin
      pad_word[7:0]  = 8'($urandom);
      pad_word[15:8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      repeat (3) @(negedge clk);
      run_poll("rand");
    end

    // Disconnected line, then an official pad
    pad_disc = 1'b1;
    run_poll("disc");
    pad_disc = 1'b0;
    pad_word = {8'hFF, BTN_B};
    run_poll("official");

    // Counter-driven polls; poll_req during CLK_LO must be dropped
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    observe(1100, -1);
    check("period_first_idx", ob_start - c0 - 1, P - 1);
    check_txn("period1");
    s1 = ob_start;
    observe(1100, 3 * H + 1);
    check("period_second", ob_start - s1, P);
    check_txn("period2_req_in_clklo");
    s2 = ob_start;
    observe(1100, -1);
    check("period_third", ob_start - s2, P);

    // Reset mid-transaction with A pressed
    pad_word = {8'hFF, BTN_A};
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    check("midrst_started", pad_latch, 1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_latch", pad_latch, 0);
    check("midrst_clk", pad_clk, 1);
    check("midrst_btns", btns, 0);
    check("midrst_valid", btns_valid, 0);
    rst = 1'b0;
    c0 = cyc;
    vcnt = 0;
    n = 0;
    while (!pad_latch && n < 1100) begin
      if (btns_valid) vcnt++;
      @(negedge clk);
      n++;
    end
    check("midrst_no_valid", vcnt, 0);
    check("midrst_next_idx", cyc - c0 - 1, P - 1);
    observe(1, -1);
    check_txn("after_midrst");

    // poll_req on the same cycle the counter reaches P-1
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    while (cyc - c0 < P - 1) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    observe(1, -1);
    check("coincide_idx", ob_start - c0 - 1, P - 1);
    check_txn("coincide");
    s1 = ob_start;
    observe(1100, -1);
    check("coincide_next", ob_start - s1, P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_pad_poller.md
# nes_pad_poller

Host-side initiator for the NES controller serial protocol. It drives the latch and shift-clock lines of a physical NES pad wired to FPGA pins and samples the active-low serial data line. It publishes a parallel, active-high 8-bit button state once per poll period. The block sits on the board top level and feeds the cart/NES controller-state inputs, replacing simulated controllers on hardware.

## Interface
Parameters:
- HALF_CYCLES, 128: clk cycles per half shift-clock period. Minimum 4.
- POLL_CYCLES, 357954: clk cycles from one poll start to the next (about 60 Hz at 21.477 MHz). Must exceed one full transaction.

Ports:
- clk  in  1  master clock
- rst  in  1  reset: synchronous, active-high
- poll_req  in  1  one-cycle request to start a poll immediately. Ignored while a transaction is in progress.
- pad_data  in  1  serial data from the pad. Asynchronous. Active-low: wire 0 means pressed.
- pad_latch  out  1  latch/strobe to the pad. Active-high.
- pad_clk  out  1  shift clock to the pad. Idles high.
- btns  out  8  button state, 1 = pressed. Bit mapping: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- btns_valid  out  1  one-cycle pulse when btns is updated.
- pad_present  out  1  pad detected. See Configuration.

## Operation
- pad_data passes through a 2-flop synchronizer. The sampled bit is the inverted synchronizer output.
- NBITS is 8, or 16 when PAD_POLLER_DETECT_EN is defined. NBITS bits are captured LSB-first into a shift register.
- State machine:
  - IDLE: pad_latch=0, pad_clk=1. The poll counter increments. Go to LATCH when the counter reaches POLL_CYCLES-1 or poll_req=1.
  - LATCH: pad_latch=1 for 2·HALF_CYCLES cycles, then go to SETTLE. The poll counter clears on entry.
  - SETTLE: pad_latch=0 for HALF_CYCLES cycles. Sample bit 0 on the last cycle, then go to CLK_LO.
  - CLK_LO: pad_clk=0 for HALF_CYCLES cycles, then go to CLK_HI.
  - CLK_HI: pad_clk=1 for HALF_CYCLES cycles. Sample the next bit on the last cycle. Go to CLK_LO if bits remain, otherwise go to DONE. This produces NBITS-1 clock pulses in total.
  - DONE: one cycle. btns ← shift[7:0], btns_valid=1, pad_present is updated. Then go to IDLE.
- The poll counter keeps running through a transaction, so polls are periodic from start to start.
- poll_req is not queued. A request that arrives outside IDLE is dropped.
- If poll_req arrives on the same cycle the counter reaches POLL_CYCLES-1, exactly one poll starts.
- All outputs are registered.

## Timing
- Cycle 0 is the first cycle with pad_latch=1. H = HALF_CYCLES.
  - pad_latch is high for cycles 0..2H-1.
  - Bit 0 is sampled at cycle 3H-1.
  - Pulse k (k = 1..NBITS-1) drives pad_clk low for cycles 3H+(k-1)·2H .. 3H+(k-1)·2H+H-1. Bit k is sampled at 3H+k·2H-1.
  - btns_valid is high at cycle 3H+(NBITS-1)·2H. btns changes on that same cycle.
- The sample reflects pad_data from 2 cycles earlier. pad_data must be stable for at least 3 cycles before each sample point; H ≥ 4 guarantees this.
- Reset values: pad_latch=0, pad_clk=1, btns=0, btns_valid=0, pad_present=0, counter=0, state IDLE.
- With no poll_req, the first poll starts POLL_CYCLES-1 cycles after reset is released.
- Reset mid-transaction aborts immediately. All outputs return to their reset values and btns is not updated.

## Configuration
- PAD_POLLER_DETECT_EN defined:
  - NBITS=16.
  - pad_present=1 only when all of bits 8..15 read 1. This matches an official pad shifting out its grounded serial input.
  - When pad_present=0, btns is forced to 0. This covers an open line, where the pull-up reads all zeros.
- PAD_POLLER_DETECT_EN undefined:
  - NBITS=8.
  - pad_present is set to 1 on the first DONE and stays 1 until reset.

## Structure
- Package nes_pad_pkg holds:
  - the state enum (IDLE, LATCH, SETTLE, CLK_LO, CLK_HI, DONE);
  - BTN_A..BTN_RIGHT bit constants (8'h01..8'h80);
  - the localparam NBITS derivation.
- One sub-module, pad_sync2: a 2-flop synchronizer with reset value 1 (wire idle high).
- The top holds the FSM, the half-period counter, the bit index, the poll counter and the shift register.

## Test plan
Bench parameters: HALF_CYCLES=4, POLL_CYCLES=1000. The pad model shifts on the pad_clk rising edge and reloads while pad_latch=1.
- Pad model with Start+Right pressed (wire-low bits 3 and 7), poll_req at cycle 10 after reset → pad_latch high for 8 cycles and 7 pad_clk low pulses of 4 cycles each. btns_valid at start+68 (8-bit build) or start+132 (detect build), with btns=8'h88.
- No poll_req → poll starts at cycle 999 after reset, and again 1000 cycles later. btns_valid pulses exactly once per poll.
- poll_req asserted during CLK_LO → no restart and no second btns_valid. Counter-driven timing is unchanged.
- Detect build, pad_data held high (disconnected) → btns=0 and pad_present=0. With a pad model returning 1s after 8 bits → pad_present=1.
- rst pulsed at start+30 with A pressed → pad_latch=0, pad_clk=1 and btns=0 the next cycle. No btns_valid until the next poll.
- poll_req on the same cycle the counter hits 999 → a single transaction and a single btns_valid.
